// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and the timing floor
// set by the fullAdder cell's combinational path.
package serial_adder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Two XOR stages of 50 units each, with margin for clock-to-q and setup.
    localparam int SERIAL_ADDER_MIN_PERIOD = 200;

    function automatic logic is_last_bit(input int unsigned count, input int unsigned width);
        return count == width - 1;
    endfunction

endpackage

// File: rtl/fullAdder.sv
// Single-bit full adder cell; the only arithmetic in the serial adder datapath.
module fullAdder (
    output logic sum,
    output logic carryout,
    input  logic a,
    input  logic b,
    input  logic carryin
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign sum      = half_sum ^ carryin;
    assign carryout = (a & b) | (carryin & half_sum);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: captures operands, then adds one bit per clock LSB first
// through a single fullAdder, holding the registered result until the next completes.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic             carry_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_next;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    fullAdder u_fa (
        .sum      (fa_sum),
        .carryout (fa_cout),
        .a        (op_a[0]),
        .b        (op_b[0]),
        .carryin  (carry_q)
    );

    assign sum_next = {fa_sum, sum_sr[WIDTH-1:1]};
    assign last_bit = is_last_bit(32'(count), 32'(WIDTH));
    assign ready    = (state != ADD);
    assign done     = (state == DONE);

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values
    // and the shift registers, carry FF and result regs update together without ordering races.
    // The operand/sum shift registers are ordinary flops, so clearing them on reset is cheap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            carry_q  <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            sum_sr   <= '0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a    <= a;
                        op_b    <= b;
                        carry_q <= carryin;
                        count   <= '0;
                        state   <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADD: begin
                    op_a    <= op_a >> 1;
                    op_b    <= op_b >> 1;
                    sum_sr  <= sum_next;
                    carry_q <= fa_cout;
                    if (last_bit) begin
                        // carry_q here is the carry into the MSB.
                        sum      <= sum_next;
                        carryout <= fa_cout;
                        overflow <= carry_q ^ fa_cout;
                        state    <= DONE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed boundary cases plus
// randomized operations compared against an arithmetic reference model.
module tb_serial_adder;

    localparam int WIDTH  = 8;
    localparam int PERIOD = 200;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] last_sum;
    logic             last_co;
    logic             last_ov;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .carryin  (carryin),
        .ready    (ready),
        .done     (done),
        .sum      (sum),
        .carryout (carryout),
        .overflow (overflow)
    );

    always #(PERIOD / 2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: unsigned sum with carry, and signed overflow from the true signed total.
    task automatic model(input logic [7:0] x, input logic [7:0] y, input logic ci,
                         output logic [7:0] s, output logic co, output logic ov);
        int unsigned total;
        int          stotal;
        total  = int'(x) + int'(y) + int'(ci);
        stotal = int'($signed(x)) + int'($signed(y)) + int'(ci);
        s      = total[7:0];
        co     = total > 255;
        ov     = (stotal > 127) || (stotal < -128);
    endtask

    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic ci);
        start   = 1'b1;
        a       = x;
        b       = y;
        carryin = ci;
    endtask

    // Called at the negedge where the op was driven; returns at the negedge of the DONE cycle.
    task automatic await_result(input logic [7:0] x, input logic [7:0] y, input logic ci,
                                input bit hold, input string tag);
        logic [7:0] es;
        logic       eco;
        logic       eov;
        model(x, y, ci, es, eco, eov);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            if (hold) begin
                a       = 8'($urandom);
                b       = 8'($urandom);
                carryin = 1'($urandom);
            end else if (i == 0) begin
                start = 1'b0;
            end
            check({tag, "_busy_ready"}, 32'(ready), 32'(0));
            check({tag, "_busy_done"}, 32'(done), 32'(0));
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'(1));
        check({tag, "_ready"}, 32'(ready), 32'(1));
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_co"}, 32'(carryout), 32'(eco));
        check({tag, "_ov"}, 32'(overflow), 32'(eov));
        last_sum = es;
        last_co  = eco;
        last_ov  = eov;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        carryin = 1'b0;

        #30 rst_n = 1'b1;
        #20;
        check("reset_ready", 32'(ready), 32'(1));
        check("reset_done", 32'(done), 32'(0));
        check("reset_sum", 32'(sum), 32'(0));
        check("reset_co", 32'(carryout), 32'(0));
        check("reset_ov", 32'(overflow), 32'(0));

        // Basic op, then boundaries back-to-back (each accepted in the prior DONE cycle).
        @(negedge clk);
        drive(8'h0F, 8'h01, 1'b0); await_result(8'h0F, 8'h01, 1'b0, 1'b0, "basic");
        drive(8'hFF, 8'h01, 1'b0); await_result(8'hFF, 8'h01, 1'b0, 1'b0, "ff_p_01");
        drive(8'h7F, 8'h01, 1'b0); await_result(8'h7F, 8'h01, 1'b0, 1'b0, "7f_p_01");
        drive(8'h80, 8'h80, 1'b0); await_result(8'h80, 8'h80, 1'b0, 1'b0, "80_p_80");
        drive(8'hFF, 8'hFF, 1'b1); await_result(8'hFF, 8'hFF, 1'b1, 1'b0, "ff_p_ff_c");

        // Done pulse lasts one cycle and the result is held afterwards.
        @(negedge clk);
        check("pulse_done_low", 32'(done), 32'(0));
        check("hold_sum", 32'(sum), 32'(8'hFF));

        // start held through ADD with changing operands: ignored until DONE.
        drive(8'h0F, 8'h01, 1'b0); await_result(8'h0F, 8'h01, 1'b0, 1'b1, "held_start");
        drive(8'h22, 8'h11, 1'b1); await_result(8'h22, 8'h11, 1'b1, 1'b0, "in_done");

        // Reset during the 4th ADD cycle aborts the op.
        @(negedge clk);
        drive(8'h55, 8'h33, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'(1));
        check("abort_done", 32'(done), 32'(0));
        check("abort_sum", 32'(sum), 32'(0));
        check("abort_co", 32'(carryout), 32'(0));
        check("abort_ov", 32'(overflow), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'(0));
        end
        drive(8'h01, 8'h02, 1'b0); await_result(8'h01, 8'h02, 1'b0, 1'b0, "after_reset");

        for (int n = 0; n < 500; n++) begin
            int unsigned gap;
            logic [7:0]  x;
            logic [7:0]  y;
            logic        ci;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < int'(gap); g++) begin
                @(negedge clk);
                start = 1'b0;
                check("rnd_idle_done", 32'(done), 32'(0));
                check("rnd_idle_held", 32'({last_ov, last_co, last_sum}),
                      32'({overflow, carryout, sum}) ^ 32'(0));
            end
            x  = 8'($urandom);
            y  = 8'($urandom);
            ci = 1'($urandom);
            drive(x, y, ci);
            await_result(x, y, ci, 1'b0, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
